add_sub_seq: RTL

- Parametrised, multi-cycle two's-complement adder/subtractor. Successor to the fixed-width combinational ripple adder-subtractor.
- Processes CHUNK bits per clock over a WIDTH-bit operand pair.
- Uses valid/ready handshakes on input and output, and reports Carry, signed Overflow and Zero flags.
- Sits between operand registers and the ALU result bus of the AUC datapath.

---
 rtl/add_sub_if.sv | 11 +
 rtl/add_sub_seq.sv | 81 ++++++++
 2 files changed

// File: rtl/add_sub_if.sv
// add_sub_if: operand/result handshake bundle for add_sub_seq
// master drives operands and out_ready; slave returns the result and flags
interface add_sub_if #(parameter int WIDTH = 4);
   logic             in_valid, in_ready, s;
   logic [WIDTH-1:0] a, b, sum;
   logic             out_valid, out_ready, carry, overflow, zero;
   modport master (output in_valid, a, b, s, out_ready,
                   input  in_ready, out_valid, sum, carry, overflow, zero);
   modport slave  (input  in_valid, a, b, s, out_ready,
                   output in_ready, out_valid, sum, carry, overflow, zero);
endinterface

// File: rtl/add_sub_seq.sv
// add_sub_seq: multi-cycle chunked two's-complement adder/subtractor with C/V/Z flags
// define ADDSUB_SAT_EN to clamp overflowed results to signed saturation
module add_sub_seq #(
   parameter int WIDTH = 4,
   parameter int CHUNK = 1
) (
   input logic clk,
   input logic rst,
   add_sub_if.slave io
);
   localparam int NCH = WIDTH / CHUNK;
   localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
   logic [1:0]       state;
   logic [WIDTH-1:0] ra, rb, acc, nxt_acc, res, sum_r;
   logic [CW-1:0]    cnt;
   logic [CHUNK:0]   part;
   logic             cy, cout, cin_msb, ovf, last, carry_r, ovf_r, zero_r;
   assign part    = {1'b0, ra[cnt*CHUNK +: CHUNK]} + {1'b0, rb[cnt*CHUNK +: CHUNK]} + (CHUNK+1)'(cy);
   assign cout    = part[CHUNK];
   assign last    = cnt == CW'(NCH - 1);
   always_comb begin
      nxt_acc = acc;
      nxt_acc[cnt*CHUNK +: CHUNK] = part[CHUNK-1:0];
   end
   // carry into the MSB recovered from its sum bit: s = a ^ b' ^ cin
   assign cin_msb = ra[WIDTH-1] ^ rb[WIDTH-1] ^ nxt_acc[WIDTH-1];
   assign ovf     = cin_msb ^ cout;
`ifdef ADDSUB_SAT_EN
   logic [WIDTH-1:0] sat;
   assign sat = {ra[WIDTH-1], {(WIDTH-1){~ra[WIDTH-1]}}};
   assign res = ovf ? sat : nxt_acc;
`else
   assign res = nxt_acc;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ra      <= '0;
         rb      <= '0;
         acc     <= '0;
         cy      <= 1'b0;
         cnt     <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         ovf_r   <= 1'b0;
         zero_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (io.in_valid) begin
               ra    <= io.a;
               rb    <= io.b ^ {WIDTH{io.s}};
               cy    <= io.s;
               cnt   <= '0;
               acc   <= '0;
               state <= CALC;
            end
            CALC: begin
               acc <= nxt_acc;
               cy  <= cout;
               cnt <= cnt + 1'b1;
               if (last) begin
                  sum_r   <= res;
                  carry_r <= cout;
                  ovf_r   <= ovf;
                  zero_r  <= res == '0;
                  state   <= DONE;
               end
            end
            DONE: if (io.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   assign io.in_ready  = state == IDLE && !rst;
   assign io.out_valid = state == DONE;
   assign io.sum       = sum_r;
   assign io.carry     = carry_r;
   assign io.overflow  = ovf_r;
   assign io.zero      = zero_r;
endmodule
